// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA write-burst arbiter.
// Holds the arbiter state encoding, the largest supported channel count
// and the round-robin pick function used by dma_wr_burst_arb.
package dma_arb_pkg;

    localparam int MAXCH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Returns the first set bit of req at or after ptr, wrapping around.
    // Request bits at and above the real channel count are always zero.
    // That makes wrapping modulo MAXCH equivalent to wrapping modulo NCH.
    // The loop runs from the largest offset down to the smallest.
    // The closest requester is therefore the last one written and wins.
    function automatic logic [2:0] rr_pick(input logic [MAXCH-1:0] req,
                                           input logic [2:0]       ptr);
        logic [2:0] idx;
        logic [2:0] sel;
        sel = ptr;
        for (int k = MAXCH - 1; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/dma_arb_idfifo.sv
// Owner-ID FIFO for the DMA write-burst arbiter.
// Stores the channel index of every issued burst, in issue order.
// Each write response can then be routed back to its owner.
// A push while full and a pop while empty are ignored.
module dma_arb_idfifo
    import dma_arb_pkg::*;
#(
    parameter int IW = 2,
    parameter int OW = 3
) (
    input  logic          clk,
    input  logic          bus_rst_n,
    input  logic          push,
    input  logic [IW-1:0] din,
    input  logic          pop,
    output logic [IW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [OW:0]   level
);

    localparam int DEPTH = 1 << OW;

    logic [IW-1:0] mem [DEPTH];
    logic [OW-1:0] wr_ptr;
    logic [OW-1:0] rd_ptr;
    logic [OW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (OW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage array; no reset needed, because entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dma_wr_burst_arb.sv
// Round-robin arbiter that shares one Avalon burst-write master between NCH
// DMA write channels.
// A channel keeps the master for a whole burst, from sob to eob.
// The owner of every issued burst is queued so that each write response
// returns to the channel that issued the burst.
// Optional feature: define DMA_ARB_CNT_EN to get per-channel 16-bit counters
// of issued bursts on cnt_bst. When it is undefined, cnt_bst is tied to 0.
module dma_wr_burst_arb
    import dma_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 32,
    parameter int BL  = 4,
    parameter int OW  = 3
) (
    input  logic                clk,
    input  logic                bus_rst_n,
    input  logic [NCH*AW-1:0]   ch_adr,
    input  logic [NCH*(BL+1)-1:0] ch_len,
    input  logic [NCH-1:0]      ch_sob,
    input  logic [NCH-1:0]      ch_eob,
    input  logic [NCH-1:0]      ch_val,
    output logic [NCH-1:0]      ch_rdy,
    output logic [NCH-1:0]      ch_rsp,
    output logic [AW-1:0]       m_adr,
    output logic [BL:0]         m_len,
    output logic                m_sob,
    output logic                m_eob,
    output logic                m_val,
    input  logic                m_rdy,
    input  logic                m_rsp,
    output logic                busy,
    output logic                rsp_err,
    output logic [NCH*16-1:0]   cnt_bst
);

    localparam int IW    = $clog2(NCH);
    localparam int DEPTH = 1 << OW;

    arb_state_e    state;
    arb_state_e    state_d;
    logic [IW-1:0] gnt;
    logic [IW-1:0] gnt_d;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_d;
    logic [IW-1:0] pick;
    logic [MAXCH-1:0] req_ext;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [IW-1:0] fifo_head;
    logic [OW:0]   fifo_level;
    logic [OW+1:0] outstanding;
    logic          can_grant;
    logic          issue_eob;

    assign req_ext     = MAXCH'(ch_val & ch_sob);
    assign pick        = IW'(rr_pick(req_ext, 3'(rr_ptr)));
    assign outstanding = {1'b0, fifo_level} + (OW+2)'(state == GRANT);
    assign can_grant   = ~fifo_full & (outstanding < (OW+2)'(DEPTH));
    assign issue_eob   = (state == GRANT) & m_val & m_rdy & m_eob;
    assign fifo_pop    = m_rsp & ~fifo_empty;
    assign busy        = (state == GRANT) | (fifo_level != '0);

    // State, grant owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            gnt    <= gnt_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    // Take a grant only at a start-of-burst, and only when a response slot is free.
    // Release the grant on the accepted eob beat and queue the owner at that point.
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        rr_ptr_d  = rr_ptr;
        fifo_push = 1'b0;
        case (state)
            IDLE: begin
                if ((req_ext != '0) && can_grant) begin
                    gnt_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (issue_eob) begin
                    fifo_push = 1'b1;
                    state_d   = IDLE;
                    if (gnt == IW'(NCH - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Steer the granted channel onto the master and hand m_rdy back to that channel only.
    always_comb begin
        m_adr  = '0;
        m_len  = '0;
        m_sob  = 1'b0;
        m_eob  = 1'b0;
        m_val  = 1'b0;
        ch_rdy = '0;
        if (state == GRANT) begin
            for (int i = 0; i < NCH; i++) begin
                if (gnt == IW'(i)) begin
                    m_adr     = ch_adr[i*AW +: AW];
                    m_len     = ch_len[i*(BL+1) +: (BL+1)];
                    m_sob     = ch_sob[i];
                    m_eob     = ch_eob[i];
                    m_val     = ch_val[i];
                    ch_rdy[i] = m_rdy;
                end
            end
        end
    end

    // Route each response pulse to the channel at the head of the owner queue.
    always_comb begin
        ch_rsp = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_rsp[i] = fifo_pop & (fifo_head == IW'(i));
        end
    end

    // Sticky error flag for a response that arrives with no burst outstanding.
    always_ff @(posedge clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            rsp_err <= 1'b0;
        end else if (m_rsp & fifo_empty) begin
            rsp_err <= 1'b1;
        end
    end

    dma_arb_idfifo #(
        .IW (IW),
        .OW (OW)
    ) u_idfifo (
        .clk       (clk),
        .bus_rst_n (bus_rst_n),
        .push      (fifo_push),
        .din       (gnt),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef DMA_ARB_CNT_EN
    logic [15:0] cnt_q [NCH];

    // Count issued bursts per channel, on the accepted eob beat; the counters wrap.
    always_ff @(posedge clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (issue_eob) begin
            cnt_q[gnt] <= cnt_q[gnt] + 16'd1;
        end
    end

    // Flatten the counter array onto the cnt_bst output bus.
    always_comb begin
        cnt_bst = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_bst[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    assign cnt_bst = '0;
`endif

endmodule

// File: tb/tb_dma_wr_burst_arb.sv
// Directed testbench for dma_wr_burst_arb.
// Configuration: NCH=4, AW=32, BL=4, OW=1, so at most two bursts can be outstanding.
module tb_dma_wr_burst_arb;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int BL  = 4;
    localparam int OW  = 1;

`ifdef DMA_ARB_CNT_EN
    localparam logic [15:0] EXP_CNT2 = 16'd5;
`else
    localparam logic [15:0] EXP_CNT2 = 16'd0;
`endif

    logic                    clk;
    logic                    bus_rst_n;
    logic [NCH*AW-1:0]       ch_adr;
    logic [NCH*(BL+1)-1:0]   ch_len;
    logic [NCH-1:0]          ch_sob;
    logic [NCH-1:0]          ch_eob;
    logic [NCH-1:0]          ch_val;
    logic [NCH-1:0]          ch_rdy;
    logic [NCH-1:0]          ch_rsp;
    logic [AW-1:0]           m_adr;
    logic [BL:0]             m_len;
    logic                    m_sob;
    logic                    m_eob;
    logic                    m_val;
    logic                    m_rdy;
    logic                    m_rsp;
    logic                    busy;
    logic                    rsp_err;
    logic [NCH*16-1:0]       cnt_bst;

    int total;
    int bad;

    dma_wr_burst_arb #(
        .NCH (NCH),
        .AW  (AW),
        .BL  (BL),
        .OW  (OW)
    ) dut (
        .clk       (clk),
        .bus_rst_n (bus_rst_n),
        .ch_adr    (ch_adr),
        .ch_len    (ch_len),
        .ch_sob    (ch_sob),
        .ch_eob    (ch_eob),
        .ch_val    (ch_val),
        .ch_rdy    (ch_rdy),
        .ch_rsp    (ch_rsp),
        .m_adr     (m_adr),
        .m_len     (m_len),
        .m_sob     (m_sob),
        .m_eob     (m_eob),
        .m_val     (m_val),
        .m_rdy     (m_rdy),
        .m_rsp     (m_rsp),
        .busy      (busy),
        .rsp_err   (rsp_err),
        .cnt_bst   (cnt_bst)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Count a comparison and report it when it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one channel's burst-level request signals.
    task automatic applyStimulus(input int ch, input logic v, input logic s, input logic e,
                                 input logic [31:0] adr, input logic [4:0] len);
        ch_val[ch]               = v;
        ch_sob[ch]               = s;
        ch_eob[ch]               = e;
        ch_adr[ch*AW +: AW]      = adr;
        ch_len[ch*(BL+1) +: BL+1] = len;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic resetDut();
        ch_adr    = '0;
        ch_len    = '0;
        ch_sob    = '0;
        ch_eob    = '0;
        ch_val    = '0;
        m_rdy     = 1'b0;
        m_rsp     = 1'b0;
        bus_rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_rst_n = 1'b1;
    endtask

    initial begin
        int exp_order [5];
        total = 0;
        bad   = 0;
        exp_order = '{0, 1, 2, 3, 0};

        // 1: reset values, then a single 4-beat burst on ch0
        $display("[TB] test 1: single channel burst");
        resetDut();
        settle();
        checkOutput("rst busy", busy, 0);
        checkOutput("rst m_val", m_val, 0);
        checkOutput("rst ch_rdy", ch_rdy, 0);
        checkOutput("rst rsp_err", rsp_err, 0);
        checkOutput("rst ch_rsp", ch_rsp, 0);
        checkOutput("rst m_adr", m_adr, 0);
        checkOutput("rst m_len", m_len, 0);
        checkOutput("rst cnt_bst", cnt_bst, 0);
        applyStimulus(0, 1, 1, 0, 32'h100, 5'd4);
        m_rdy = 1'b1;
        settle();
        checkOutput("t1 bubble m_val", m_val, 0);
        checkOutput("t1 bubble ch_rdy", ch_rdy, 0);
        step();
        checkOutput("t1 b0 m_val", m_val, 1);
        checkOutput("t1 b0 m_adr", m_adr, 32'h100);
        checkOutput("t1 b0 m_len", m_len, 4);
        checkOutput("t1 b0 m_sob", m_sob, 1);
        checkOutput("t1 b0 ch_rdy", ch_rdy, 4'b0001);
        for (int b = 1; b < 4; b++) begin
            step();
            applyStimulus(0, 1, 0, (b == 3), 32'h100, 5'd4);
            settle();
            checkOutput("t1 beat m_val", m_val, 1);
            checkOutput("t1 beat m_sob", m_sob, 0);
            checkOutput("t1 beat m_eob", m_eob, (b == 3));
            checkOutput("t1 beat ch_rdy", ch_rdy, 4'b0001);
        end
        step();
        applyStimulus(0, 0, 0, 0, 32'h100, 5'd4);
        settle();
        checkOutput("t1 post m_val", m_val, 0);
        checkOutput("t1 post busy", busy, 1);
        m_rsp = 1'b1;
        settle();
        checkOutput("t1 ch_rsp", ch_rsp, 4'b0001);
        step();
        m_rsp = 1'b0;
        settle();
        checkOutput("t1 idle busy", busy, 0);
        checkOutput("t1 idle ch_rsp", ch_rsp, 0);

        // 2: all channels request continuously, so the grants rotate
        $display("[TB] test 2: round robin");
        resetDut();
        for (int i = 0; i < NCH; i++) begin
            applyStimulus(i, 1, 1, 1, 32'h400 + 32'(i) * 32'h10, 5'd1);
        end
        m_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m_rsp = (k > 0);
            settle();
            checkOutput("t2 idle m_val", m_val, 0);
            if (k > 0) begin
                checkOutput("t2 ch_rsp", ch_rsp, 64'(1) << exp_order[k-1]);
            end
            step();
            m_rsp = 1'b0;
            settle();
            checkOutput("t2 gnt ch_rdy", ch_rdy, 64'(1) << exp_order[k]);
            checkOutput("t2 gnt m_adr", m_adr, 32'h400 + 32'(exp_order[k]) * 32'h10);
            step();
        end

        // 3: m_rdy stalls and ch_val drops mid-burst; the grant is held
        $display("[TB] test 3: stalls and held grant");
        resetDut();
        applyStimulus(1, 1, 1, 0, 32'h200, 5'd3);
        applyStimulus(2, 1, 1, 1, 32'h300, 5'd1);
        m_rdy = 1'b0;
        settle();
        checkOutput("t3 bubble m_val", m_val, 0);
        step();
        checkOutput("t3 g m_val", m_val, 1);
        checkOutput("t3 g m_adr", m_adr, 32'h200);
        checkOutput("t3 g stall ch_rdy", ch_rdy, 0);
        step();
        m_rdy = 1'b1;
        settle();
        checkOutput("t3 b1 ch_rdy", ch_rdy, 4'b0010);
        checkOutput("t3 b1 m_sob", m_sob, 1);
        step();
        applyStimulus(1, 0, 0, 0, 32'h200, 5'd3);
        settle();
        checkOutput("t3 gap m_val", m_val, 0);
        checkOutput("t3 gap ch_rdy", ch_rdy, 4'b0010);
        checkOutput("t3 gap m_adr", m_adr, 32'h200);
        step();
        applyStimulus(1, 1, 0, 0, 32'h200, 5'd3);
        m_rdy = 1'b0;
        settle();
        checkOutput("t3 b2 stall ch_rdy", ch_rdy, 0);
        checkOutput("t3 b2 m_val", m_val, 1);
        step();
        m_rdy = 1'b1;
        settle();
        checkOutput("t3 b2 ch_rdy", ch_rdy, 4'b0010);
        step();
        applyStimulus(1, 1, 0, 1, 32'h200, 5'd3);
        settle();
        checkOutput("t3 b3 m_eob", m_eob, 1);
        checkOutput("t3 b3 ch_rdy", ch_rdy, 4'b0010);
        step();
        applyStimulus(1, 0, 0, 0, 32'h200, 5'd3);
        settle();
        checkOutput("t3 bubble2 m_val", m_val, 0);
        checkOutput("t3 bubble2 ch_rdy", ch_rdy, 0);
        step();
        checkOutput("t3 ch2 ch_rdy", ch_rdy, 4'b0100);
        checkOutput("t3 ch2 m_adr", m_adr, 32'h300);
        checkOutput("t3 ch2 m_eob", m_eob, 1);
        step();
        applyStimulus(2, 0, 0, 0, 32'h300, 5'd1);
        settle();
        checkOutput("t3 end busy", busy, 1);

        // 4: the owner FIFO fills up and stalls a third request
        $display("[TB] test 4: outstanding limit");
        resetDut();
        m_rdy = 1'b1;
        applyStimulus(0, 1, 1, 1, 32'h010, 5'd1);
        applyStimulus(1, 1, 1, 1, 32'h020, 5'd1);
        applyStimulus(3, 1, 1, 1, 32'h030, 5'd1);
        settle();
        step();
        checkOutput("t4 g0 ch_rdy", ch_rdy, 4'b0001);
        step();
        applyStimulus(0, 0, 0, 0, 32'h010, 5'd1);
        step();
        checkOutput("t4 g1 ch_rdy", ch_rdy, 4'b0010);
        step();
        applyStimulus(1, 0, 0, 0, 32'h020, 5'd1);
        for (int r = 0; r < 3; r++) begin
            settle();
            checkOutput("t4 stall m_val", m_val, 0);
            checkOutput("t4 stall ch_rdy", ch_rdy, 0);
            checkOutput("t4 stall busy", busy, 1);
            step();
        end
        m_rsp = 1'b1;
        settle();
        checkOutput("t4 rsp ch_rsp", ch_rsp, 4'b0001);
        checkOutput("t4 rsp m_val", m_val, 0);
        step();
        m_rsp = 1'b0;
        settle();
        checkOutput("t4 bubble m_val", m_val, 0);
        step();
        checkOutput("t4 g3 ch_rdy", ch_rdy, 4'b1000);
        checkOutput("t4 g3 m_adr", m_adr, 32'h030);
        step();
        applyStimulus(3, 0, 0, 0, 32'h030, 5'd1);

        // 5: a response with nothing outstanding sets the sticky error
        $display("[TB] test 5: orphan response");
        resetDut();
        m_rsp = 1'b1;
        settle();
        checkOutput("t5 ch_rsp", ch_rsp, 0);
        checkOutput("t5 err pre", rsp_err, 0);
        step();
        m_rsp = 1'b0;
        settle();
        checkOutput("t5 err set", rsp_err, 1);
        step();
        step();
        checkOutput("t5 err sticky", rsp_err, 1);
        resetDut();
        settle();
        checkOutput("t5 err cleared", rsp_err, 0);

        // 6: a push and a pop in the same cycle
        $display("[TB] test 6: push and pop together");
        resetDut();
        m_rdy = 1'b1;
        applyStimulus(2, 1, 1, 1, 32'h500, 5'd1);
        settle();
        step();
        checkOutput("t6 g2 ch_rdy", ch_rdy, 4'b0100);
        step();
        applyStimulus(2, 0, 0, 0, 32'h500, 5'd1);
        applyStimulus(1, 1, 1, 1, 32'h600, 5'd1);
        settle();
        step();
        m_rsp = 1'b1;
        settle();
        checkOutput("t6 g1 ch_rdy", ch_rdy, 4'b0010);
        checkOutput("t6 old head rsp", ch_rsp, 4'b0100);
        step();
        m_rsp = 1'b0;
        applyStimulus(1, 0, 0, 0, 32'h600, 5'd1);
        settle();
        checkOutput("t6 level kept", busy, 1);
        m_rsp = 1'b1;
        settle();
        checkOutput("t6 new head rsp", ch_rsp, 4'b0010);
        step();
        m_rsp = 1'b0;
        settle();
        checkOutput("t6 drained busy", busy, 0);

        // Five ch2 bursts for the optional counters (zero when they are compiled out)
        $display("[TB] test 7: burst counters");
        resetDut();
        m_rdy = 1'b1;
        applyStimulus(2, 1, 1, 1, 32'h700, 5'd1);
        for (int k = 0; k < 5; k++) begin
            m_rsp = (k > 0);
            settle();
            step();
            m_rsp = 1'b0;
            settle();
            step();
        end
        applyStimulus(2, 0, 0, 0, 32'h700, 5'd1);
        settle();
        checkOutput("t7 cnt ch2", cnt_bst[2*16 +: 16], EXP_CNT2);
        checkOutput("t7 cnt ch0", cnt_bst[0 +: 16], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
